lcd_responder: RTL and testbench

- Bus-level responder for the HD44780-style parallel LCD interface; it is the display side of the command stream our LCD init and write sequencers drive.
- Samples E/RS/RW/DB and decodes instructions and data writes.
- Maintains display mode flags, address counter (AC) and an 80-byte DDRAM.
- Models busy time and drives busy-flag/AC and DDRAM reads back onto the bus.
- Used as the bench/emulation target for the LCD driver modules.

---
 rtl/lcd_pkg.sv | 81 ++++++++
 rtl/lcd_ddram.sv | 22 ++
 rtl/lcd_responder.sv | 243 ++++++++++++++++++++++++
 tb/tb_lcd_responder.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780-style LCD bus responder: opcodes,
// transfer classes, FSM states and small address helpers.
package lcd_pkg;

  localparam int         DDRAM_SIZE = 80;
  localparam logic [7:0] SPACE_CHAR = 8'h20;
  localparam logic [6:0] ADDR_LAST  = 7'(DDRAM_SIZE - 1);

  localparam logic [7:0] CMD_CLEAR = 8'h01;
  localparam logic [7:0] CMD_HOME  = 8'h02;
  localparam logic [7:0] CMD_ENTRY = 8'h04;
  localparam logic [7:0] CMD_DISP  = 8'h08;
  localparam logic [7:0] CMD_SHIFT = 8'h10;
  localparam logic [7:0] CMD_FUNC  = 8'h20;
  localparam logic [7:0] CMD_CGRAM = 8'h40;
  localparam logic [7:0] CMD_DDRAM = 8'h80;

  typedef enum logic [3:0] {
    CC_NONE   = 4'd0,
    CC_CLEAR  = 4'd1,
    CC_HOME   = 4'd2,
    CC_ENTRY  = 4'd3,
    CC_DISP   = 4'd4,
    CC_SHIFT  = 4'd5,
    CC_FUNC   = 4'd6,
    CC_CGRAM  = 4'd7,
    CC_DDRAM  = 4'd8,
    CC_DATAWR = 4'd9,
    CC_DATARD = 4'd10
  } cmd_code_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_CLRFILL
  } state_t;

  typedef struct packed {
    logic       e;
    logic       rs;
    logic       rw;
    logic [7:0] db;
  } bus_sample_t;

  typedef struct packed {
    logic disp_on;
    logic cursor_on;
    logic blink_on;
    logic inc_dec;
    logic shift_en;
    logic two_line;
  } mode_t;

  localparam mode_t MODE_RESET = '{disp_on: 1'b0, cursor_on: 1'b0, blink_on: 1'b0,
                                   inc_dec: 1'b1, shift_en: 1'b0, two_line: 1'b0};

  // Bits of the init-tracking vector; InitOk is the AND of all four.
  localparam int SEEN_FUNC  = 0;
  localparam int SEEN_DISP  = 1;
  localparam int SEEN_CLEAR = 2;
  localparam int SEEN_ENTRY = 3;

  // The highest set bit selects the instruction, so magnitude compares suffice.
  function automatic cmd_code_t classify(input logic [7:0] ir);
    if      (ir >= CMD_DDRAM) return CC_DDRAM;
    else if (ir >= CMD_CGRAM) return CC_CGRAM;
    else if (ir >= CMD_FUNC)  return CC_FUNC;
    else if (ir >= CMD_SHIFT) return CC_SHIFT;
    else if (ir >= CMD_DISP)  return CC_DISP;
    else if (ir >= CMD_ENTRY) return CC_ENTRY;
    else if (ir >= CMD_HOME)  return CC_HOME;
    else if (ir >= CMD_CLEAR) return CC_CLEAR;
    else                      return CC_NONE;
  endfunction

  function automatic logic [6:0] addr_step(input logic [6:0] a, input logic up);
    if (up) return (a == ADDR_LAST) ? 7'd0 : a + 7'd1;
    else    return (a == 7'd0) ? ADDR_LAST : a - 7'd1;
  endfunction

endpackage

// File: rtl/lcd_ddram.sv
// 80x8 single-port synchronous DDRAM; one write port shared by data writes
// and the clear fill, read data registered one cycle after the address.
module lcd_ddram
  import lcd_pkg::*;
(
  input  logic       clk,
  input  logic       we,
  input  logic [6:0] addr,
  input  logic [7:0] wdata,
  output logic [7:0] rdata
);

  logic [7:0] mem [DDRAM_SIZE];

  // NOTE: the array has no reset; its contents are don't-care after reset and
  // a reset term would keep it from mapping onto a RAM macro.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/lcd_responder.sv
// Display-side responder for the HD44780 parallel bus: synchronises the bus,
// decodes transfers on E fall, models busy time and drives reads back.
module lcd_responder
  import lcd_pkg::*;
#(
  parameter int BUSY_CYC  = 2000,
  parameter int CLEAR_CYC = 82000
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       LcdE,
  input  logic       LcdRS,
  input  logic       LcdRW,
  input  logic [7:0] LcdDBIn,
  output logic [7:0] LcdDBOut,
  output logic       LcdDBOe,
  output logic       Busy,
  output logic [6:0] Addr,
  output logic       DispOn,
  output logic       CursorOn,
  output logic       BlinkOn,
  output logic       IncDec,
  output logic       ShiftEn,
  output logic       TwoLine,
  output logic       InitOk,
  output logic       CmdStrobe,
  output logic [3:0] CmdCode,
  output logic       ProtoErr
);

  localparam int               CNT_MAX    = (CLEAR_CYC > BUSY_CYC) ? CLEAR_CYC : BUSY_CYC;
  localparam int               CNT_W      = $clog2(CNT_MAX);
  localparam logic [CNT_W-1:0] BUSY_LOAD  = CNT_W'(BUSY_CYC - 1);
  localparam logic [CNT_W-1:0] CLEAR_LOAD = CNT_W'(CLEAR_CYC - 1);

  bus_sample_t      sync1, bus;
  logic             e_prev;
  logic             fall;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [6:0]       fill_addr, fill_n;
  logic [6:0]       addr, addr_n;
  mode_t            mode, mode_n;
  logic [3:0]       seen, seen_n;
  logic             strobe, strobe_n;
  logic             err, err_n;
  cmd_code_t        code, code_n;

  logic             accept;
  cmd_code_t        cls;
  logic [CNT_W-1:0] load;
  state_t           go;

  logic             ram_we;
  logic [6:0]       ram_addr;
  logic [7:0]       ram_wdata, ram_rdata;
  logic [7:0]       db_out;
  logic             db_oe;
  logic             busy;

  // Two-flop synchroniser on the whole bus; E is delayed once more for edge detect.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      sync1  <= '0;
      bus    <= '0;
      e_prev <= 1'b0;
    end else begin
      sync1  <= '{e: LcdE, rs: LcdRS, rw: LcdRW, db: LcdDBIn};
      bus    <= sync1;
      e_prev <= bus.e;
    end
  end

  assign fall = e_prev & ~bus.e;
  assign busy = (state != S_IDLE);

  // NOTE: every signal driven here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    fill_n    = fill_addr;
    addr_n    = addr;
    mode_n    = mode;
    seen_n    = seen;
    code_n    = code;
    strobe_n  = 1'b0;
    err_n     = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = addr;
    ram_wdata = bus.db;
    accept    = 1'b0;
    cls       = CC_NONE;
    load      = BUSY_LOAD;
    go        = S_EXEC;

    case (state)
      S_EXEC: begin
        if (cnt == '0) state_n = S_IDLE;
        else           cnt_n   = cnt - 1'b1;
      end
      S_CLRFILL: begin
        ram_we    = 1'b1;
        ram_addr  = fill_addr;
        ram_wdata = SPACE_CHAR;
        if (cnt != '0) cnt_n = cnt - 1'b1;
        if (fill_addr == ADDR_LAST) state_n = (cnt == '0) ? S_IDLE : S_EXEC;
        else                        fill_n  = fill_addr + 7'd1;
      end
      default: ;
    endcase

    // Status reads never count as transfers; everything else needs IDLE.
    if (fall && !(bus.rw && !bus.rs)) begin
      if (state != S_IDLE) begin
        accept = 1'b0;
      end else if (bus.rs) begin
        accept = 1'b1;
        cls    = bus.rw ? CC_DATARD : CC_DATAWR;
        ram_we = !bus.rw;
        addr_n = addr_step(addr, mode.inc_dec);
      end else begin
        accept = 1'b1;
        cls    = classify(bus.db);
        case (cls)
          CC_DDRAM: begin
            if (bus.db[6:0] < 7'(DDRAM_SIZE)) addr_n = bus.db[6:0];
            else                              accept = 1'b0;
          end
          CC_FUNC: begin
            if (bus.db[4]) begin
              mode_n.two_line   = bus.db[3];
              seen_n[SEEN_FUNC] = 1'b1;
            end else begin
              accept = 1'b0;
            end
          end
          CC_SHIFT: if (!bus.db[3]) addr_n = addr_step(addr, bus.db[2]);
          CC_DISP: begin
            mode_n.disp_on    = bus.db[2];
            mode_n.cursor_on  = bus.db[1];
            mode_n.blink_on   = bus.db[0];
            seen_n[SEEN_DISP] = 1'b1;
          end
          CC_ENTRY: begin
            mode_n.inc_dec     = bus.db[1];
            mode_n.shift_en    = bus.db[0];
            seen_n[SEEN_ENTRY] = 1'b1;
          end
          CC_HOME: begin
            addr_n = '0;
            load   = CLEAR_LOAD;
          end
          CC_CLEAR: begin
            addr_n             = '0;
            mode_n.inc_dec     = 1'b1;
            load               = CLEAR_LOAD;
            go                 = S_CLRFILL;
            fill_n             = '0;
            seen_n[SEEN_CLEAR] = 1'b1;
          end
          default: ;
        endcase
      end

      if (accept) begin
        state_n  = go;
        cnt_n    = load;
        strobe_n = 1'b1;
        code_n   = cls;
      end else begin
        // A rejected transfer leaves all state alone, including busy time.
        seen_n = seen;
        mode_n = mode;
        addr_n = addr;
        err_n  = 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples its next value from the same pre-edge snapshot.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      fill_addr <= '0;
      addr      <= '0;
      mode      <= MODE_RESET;
      seen      <= '0;
      strobe    <= 1'b0;
      err       <= 1'b0;
      code      <= CC_NONE;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      fill_addr <= fill_n;
      addr      <= addr_n;
      mode      <= mode_n;
      seen      <= seen_n;
      strobe    <= strobe_n;
      err       <= err_n;
      code      <= code_n;
    end
  end

  // Read-back path: drive the bus only while the synchronised E is high.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      db_out <= '0;
      db_oe  <= 1'b0;
    end else begin
      db_oe <= bus.e & bus.rw;
      if (bus.e && bus.rw) db_out <= bus.rs ? ram_rdata : {busy, addr};
      else                 db_out <= '0;
    end
  end

  lcd_ddram u_ddram (
    .clk   (Clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  assign LcdDBOut  = db_out;
  assign LcdDBOe   = db_oe;
  assign Busy      = busy;
  assign Addr      = addr;
  assign DispOn    = mode.disp_on;
  assign CursorOn  = mode.cursor_on;
  assign BlinkOn   = mode.blink_on;
  assign IncDec    = mode.inc_dec;
  assign ShiftEn   = mode.shift_en;
  assign TwoLine   = mode.two_line;
  assign InitOk    = &seen;
  assign CmdStrobe = strobe;
  assign CmdCode   = code;
  assign ProtoErr  = err;

endmodule

// File: tb/tb_lcd_responder.sv
// Scoreboard bench for lcd_responder: stimulus queues the expected transfer
// result, a monitor checks each CmdStrobe/ProtoErr pulse against it.
module tb_lcd_responder;

  logic       Clk     = 1'b0;
  logic       Reset   = 1'b1;
  logic       LcdE    = 1'b0;
  logic       LcdRS   = 1'b0;
  logic       LcdRW   = 1'b0;
  logic [7:0] LcdDBIn = 8'h00;
  logic [7:0] LcdDBOut;
  logic       LcdDBOe;
  logic       Busy;
  logic [6:0] Addr;
  logic       DispOn, CursorOn, BlinkOn, IncDec, ShiftEn, TwoLine, InitOk;
  logic       CmdStrobe;
  logic [3:0] CmdCode;
  logic       ProtoErr;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic       err;
    logic [3:0] code;
  } exp_t;
  exp_t exp_q[$];

  logic [7:0] last_rd;
  logic       last_oe;

  lcd_responder #(.BUSY_CYC(20), .CLEAR_CYC(200)) dut (
    .Clk(Clk), .Reset(Reset), .LcdE(LcdE), .LcdRS(LcdRS), .LcdRW(LcdRW),
    .LcdDBIn(LcdDBIn), .LcdDBOut(LcdDBOut), .LcdDBOe(LcdDBOe), .Busy(Busy),
    .Addr(Addr), .DispOn(DispOn), .CursorOn(CursorOn), .BlinkOn(BlinkOn),
    .IncDec(IncDec), .ShiftEn(ShiftEn), .TwoLine(TwoLine), .InitOk(InitOk),
    .CmdStrobe(CmdStrobe), .CmdCode(CmdCode), .ProtoErr(ProtoErr)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  // Monitor: every transfer pulse must match the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge Clk);
      if (CmdStrobe || ProtoErr) begin
        if (exp_q.size() == 0) begin
          check("unexpected_xfer", {30'd0, CmdStrobe, ProtoErr}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("xfer_err", ProtoErr, e.err);
          check("xfer_strobe", CmdStrobe, !e.err);
          if (!e.err) check("xfer_code", CmdCode, e.code);
        end
      end
    end
  end

  task automatic bus_cycle(input logic rs, input logic rw, input logic [7:0] db, input int hi);
    @(posedge Clk); #1 LcdRS = rs; LcdRW = rw; LcdDBIn = db;
    @(posedge Clk); #1 LcdE = 1'b1;
    repeat (hi) @(posedge Clk);
    @(negedge Clk); last_rd = LcdDBOut; last_oe = LcdDBOe;
    @(posedge Clk); #1 LcdE = 1'b0;
    repeat (6) @(posedge Clk);
    #1 LcdRS = 1'b0; LcdRW = 1'b0;
  endtask

  task automatic wr(input logic rs, input logic [7:0] db, input logic err, input logic [3:0] code);
    exp_q.push_back('{err, code});
    bus_cycle(rs, 1'b0, db, 2);
  endtask

  task automatic rd_data();
    exp_q.push_back('{1'b0, 4'd10});
    bus_cycle(1'b1, 1'b1, 8'h00, 6);
  endtask

  task automatic rd_status();
    bus_cycle(1'b0, 1'b1, 8'h00, 6);
  endtask

  task automatic wait_idle();
    int t = 0;
    while (Busy && t < 2000) begin @(negedge Clk); t++; end
    if (t == 2000) check("idle_timeout", Busy, 1'b0);
  endtask

  task automatic busy_len(output int n);
    int t = 0;
    n = 0;
    while (!Busy && t < 100) begin @(negedge Clk); t++; end
    while (Busy && n < 1000) begin @(negedge Clk); n++; end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    check("rst_busy", Busy, 1'b0);
    check("rst_addr", Addr, 7'd0);
    check("rst_flags", {DispOn, CursorOn, BlinkOn, IncDec, ShiftEn, TwoLine, InitOk}, 7'b0001000);
    check("rst_bus", {LcdDBOe, LcdDBOut}, 9'd0);
    check("rst_code", {CmdStrobe, ProtoErr, CmdCode}, 6'd0);
    @(posedge Clk); #1 Reset = 1'b0;

    // Init sequence
    wr(0, 8'h38, 0, 4'd6); wait_idle();
    wr(0, 8'h0F, 0, 4'd4); wait_idle();
    fork
      busy_len(n);
      wr(0, 8'h01, 0, 4'd1);
    join
    check("clear_busy_len", n, 200);
    check("init_ok_partial", InitOk, 1'b0);
    wr(0, 8'h06, 0, 4'd3); wait_idle();
    wr(0, 8'h80, 0, 4'd8); wait_idle();
    check("init_flags", {TwoLine, DispOn, CursorOn, BlinkOn, IncDec, ShiftEn, InitOk}, 7'b1111101);
    check("init_addr", Addr, 7'd0);

    // Busy-flag read during and after a clear
    wr(0, 8'h01, 0, 4'd1);
    rd_status();
    check("bf_busy_bit", last_rd[7], 1'b1);
    check("bf_oe", last_oe, 1'b1);
    wait_idle();
    rd_status();
    check("bf_idle", last_rd, 8'h00);

    // Busy window with a rejected write inside it
    fork
      busy_len(n);
      begin
        wr(0, 8'h0C, 0, 4'd4);
        wr(0, 8'h08, 1, 4'd0);
      end
    join
    check("busy_len", n, 20);
    check("disp_kept", {DispOn, CursorOn, BlinkOn}, 3'b100);

    // DDRAM writes/reads with address wrap
    wr(0, 8'hCF, 0, 4'd8); wait_idle();
    check("addr_79", Addr, 7'd79);
    wr(1, 8'h41, 0, 4'd9); wait_idle();
    check("addr_wrap_inc", Addr, 7'd0);
    wr(1, 8'h42, 0, 4'd9); wait_idle();
    check("addr_after_b", Addr, 7'd1);
    wr(0, 8'hCF, 0, 4'd8); wait_idle();
    rd_data(); check("ram_79", last_rd, 8'h41); wait_idle();
    rd_data(); check("ram_0", last_rd, 8'h42); wait_idle();
    check("addr_after_rd", Addr, 7'd1);
    wr(0, 8'h10, 0, 4'd5); wait_idle(); check("shift_left", Addr, 7'd0);
    wr(0, 8'h10, 0, 4'd5); wait_idle(); check("shift_wrap", Addr, 7'd79);
    wr(0, 8'h14, 0, 4'd5); wait_idle(); check("shift_right_wrap", Addr, 7'd0);

    // Rejected instructions
    wr(0, 8'h83, 0, 4'd8); wait_idle();
    wr(0, 8'hD0, 1, 4'd0);
    check("addr_kept", Addr, 7'd3);
    wr(0, 8'h28, 1, 4'd0);
    check("twoline_kept", TwoLine, 1'b1);
    check("reject_not_busy", Busy, 1'b0);

    // Clear fill, starting from decrement mode
    wr(0, 8'h04, 0, 4'd3); wait_idle();
    check("entry_dec", IncDec, 1'b0);
    wr(0, 8'h01, 0, 4'd1); wait_idle();
    check("clr_addr", Addr, 7'd0);
    check("clr_incdec", IncDec, 1'b1);
    n = 0;
    for (int i = 0; i < 80; i++) begin
      rd_data();
      if (last_rd !== 8'h20) n++;
      wait_idle();
    end
    check("fill_mismatches", n, 0);
    check("fill_addr_wrap", Addr, 7'd0);

    // Reset in the middle of a clear fill
    wr(0, 8'h01, 0, 4'd1);
    repeat (26) @(negedge Clk);
    check("busy_before_reset", Busy, 1'b1);
    #1 Reset = 1'b1;
    #1;
    check("reset_busy", Busy, 1'b0);
    check("reset_init_ok", InitOk, 1'b0);
    check("reset_disp", DispOn, 1'b0);
    repeat (2) @(posedge Clk);
    #1 Reset = 1'b0;
    repeat (4) @(posedge Clk);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
